// File: rtl/muldiv_if.sv
// Request/response bundle between the Execute stage and the RV32M multiply/divide unit.
// The master is the issuing pipeline; the slave is muldiv_unit.
interface muldiv_if #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
);
  logic                 start_i;
  logic [2:0]           op_i;
  logic [XLEN-1:0]      rs1_i;
  logic [XLEN-1:0]      rs2_i;
  logic [REGADDR_W-1:0] rd_i;
  logic                 flush_i;
  logic                 busy_o;
  logic                 valid_o;
  logic [XLEN-1:0]      result_o;
  logic [REGADDR_W-1:0] rd_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    input  busy_o, valid_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    output busy_o, valid_o, result_o, rd_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: pipelined multiplier plus a radix-2 restoring divider.
// One operation in flight; the result leaves on a single-cycle valid_o strobe tagged with rd.
module muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int REGADDR_W   = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam int CNT_W      = $clog2(XLEN + MUL_LATENCY + 1);
  localparam int MUL_LAST_I = (MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAST_I);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 rem_sel_reg;
  logic                 neg_q_reg, neg_r_reg;
  logic [XLEN-1:0]      quo_reg, rem_reg, dvs_reg;
  logic [REGADDR_W-1:0] rd_reg;
  logic [XLEN-1:0]      result_reg, result_next;
  logic [REGADDR_W-1:0] rd_out_reg, rd_out_next;

  // Request decode, including divide special cases resolved at acceptance
  logic            idle_or_done, accept;
  logic            div_signed, a_neg, b_neg, div_zero, div_ovf, div_special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    idle_or_done = (state_reg == S_IDLE) || (state_reg == S_DONE);
    accept       = bus.start_i && !bus.flush_i && idle_or_done;
    div_signed   = !bus.op_i[0];
    a_neg        = div_signed && bus.rs1_i[XLEN-1];
    b_neg        = div_signed && bus.rs2_i[XLEN-1];
    a_mag        = a_neg ? -bus.rs1_i : bus.rs1_i;
    b_mag        = b_neg ? -bus.rs2_i : bus.rs2_i;
    div_zero     = (bus.rs2_i == '0);
    div_ovf      = div_signed && (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);
    div_special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = bus.op_i[1] ? bus.rs1_i : '1;
    end else begin
      special_res = bus.op_i[1] ? '0 : bus.rs1_i;
    end
  end

  // Multiply: operands extended to 2*XLEN so one unsigned product covers all sign modes
  logic              ma_sx, mb_sx;
  logic [2*XLEN-1:0] ma_ext, mb_ext, prod;
  logic [XLEN-1:0]   mul_now, mul_tap;

  always_comb begin
    ma_sx   = (bus.op_i[1:0] != 2'b11) && bus.rs1_i[XLEN-1];
    mb_sx   = !bus.op_i[1] && bus.rs2_i[XLEN-1];
    ma_ext  = {{XLEN{ma_sx}}, bus.rs1_i};
    mb_ext  = {{XLEN{mb_sx}}, bus.rs2_i};
    prod    = ma_ext * mb_ext;
    mul_now = (bus.op_i[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  generate
    if (MUL_LATENCY > 1) begin : g_mul_pipe
      logic [MUL_LATENCY-2:0][XLEN-1:0] pipe_reg;

      // Free-running shift: only the stage aligned with the accepted op is ever consumed
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_reg <= '0;
        end else begin
          pipe_reg[0] <= mul_now;
          for (int i = 1; i < MUL_LATENCY - 1; i++) begin
            pipe_reg[i] <= pipe_reg[i-1];
          end
        end
      end

      assign mul_tap = pipe_reg[MUL_LATENCY-2];
    end else begin : g_mul_comb
      assign mul_tap = mul_now;
    end
  endgenerate

  // Restoring divide step; the final step feeds sign fix-up straight into the result register
  logic [XLEN:0]   rem_shift, diff;
  logic            q_bit;
  logic [XLEN-1:0] quo_step, rem_step, div_res;

  always_comb begin
    rem_shift = {rem_reg, quo_reg[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_reg};
    q_bit     = !diff[XLEN];
    rem_step  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_step  = {quo_reg[XLEN-2:0], q_bit};
    if (rem_sel_reg) begin
      div_res = neg_r_reg ? -rem_step : rem_step;
    end else begin
      div_res = neg_q_reg ? -quo_step : quo_step;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (!bus.op_i[2]) begin
            state_next = (MUL_LATENCY == 1) ? S_DONE : S_MUL;
          end else if (div_special) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DIV;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_MUL:   if (cnt_reg == MUL_LAST) state_next = S_DONE;
      S_DIV:   if (cnt_reg == DIV_LAST) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (bus.flush_i) begin
      state_next = S_IDLE;
    end
  end

  always_comb begin
    result_next = result_reg;
    rd_out_next = rd_out_reg;
    if (state_next == S_DONE) begin
      case (state_reg)
        S_MUL: begin
          result_next = mul_tap;
          rd_out_next = rd_reg;
        end
        S_DIV: begin
          result_next = div_res;
          rd_out_next = rd_reg;
        end
        default: begin
          result_next = bus.op_i[2] ? special_res : mul_now;
          rd_out_next = bus.rd_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      rem_sel_reg <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
      rd_reg      <= '0;
      result_reg  <= '0;
      rd_out_reg  <= '0;
    end else begin
      result_reg <= result_next;
      rd_out_reg <= rd_out_next;
      if (accept) begin
        cnt_reg     <= '0;
        rem_sel_reg <= bus.op_i[1];
        neg_q_reg   <= a_neg ^ b_neg;
        neg_r_reg   <= a_neg;
        quo_reg     <= a_mag;
        rem_reg     <= '0;
        dvs_reg     <= b_mag;
        rd_reg      <= bus.rd_i;
      end else if ((state_reg == S_MUL) || (state_reg == S_DIV)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (state_reg == S_DIV) begin
          quo_reg <= quo_step;
          rem_reg <= rem_step;
        end
      end
    end
  end

  assign bus.busy_o   = (state_reg == S_MUL) || (state_reg == S_DIV);
  assign bus.valid_o  = (state_reg == S_DONE);
  assign bus.result_o = result_reg;
  assign bus.rd_o     = rd_out_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and
// compared (value, tag, latency) whenever valid_o is seen.
module tb_muldiv_unit;
  localparam int XLEN        = 32;
  localparam int MUL_LATENCY = 2;
  localparam int REGADDR_W   = 5;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  muldiv_if #(.XLEN(XLEN), .REGADDR_W(REGADDR_W)) bus ();

  muldiv_unit #(
    .XLEN(XLEN),
    .MUL_LATENCY(MUL_LATENCY),
    .REGADDR_W(REGADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          si, sd;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    si = a;
    sd = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(si / sd);
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(si % sd);
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LATENCY;
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Drives one request at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_done);
    exp_t e;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.rd_i    = rd;
    if (expect_done) begin
      e.op  = op;
      e.res = model(op, a, b);
      e.rd  = rd;
      e.acc = cyc + 1;
      e.lat = lat_model(op, a, b);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.op_i    = 3'($urandom);
    bus.rs1_i   = $urandom;
    bus.rs2_i   = $urandom;
    bus.rd_i    = 5'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(bus.valid_o), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn op=%0d rd=%0d result=0x%08h exp=0x%08h lat=%0d", mon_e.op, bus.rd_o,
                 bus.result_o, mon_e.res, cyc - mon_e.acc + 1);
        check("result", 64'(bus.result_o), 64'(mon_e.res));
        check("rd", 64'(bus.rd_o), 64'(mon_e.rd));
        check("latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.rs1_i   = 32'h0;
    bus.rs2_i   = 32'h0;
    bus.rd_i    = 5'd0;
    bus.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_rd", 64'(bus.rd_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL with busy window
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 5'd5, 1'b1);
    check("mul_busy_e0", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    check("mul_busy_e1", 64'(bus.busy_o), 64'd0);
    wait_idle();

    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1); wait_idle();
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1); wait_idle();
    issue(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3, 1'b1); wait_idle();

    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4,  1'b1); wait_idle();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6,  1'b1); wait_idle();
    issue(3'd5, 32'd100,       32'd7, 5'd7,  1'b1); wait_idle();
    issue(3'd7, 32'd100,       32'd7, 5'd8,  1'b1); wait_idle();

    // Special cases issued back-to-back from DONE
    issue(3'd5, 32'h0000_1234, 32'h0, 5'd9,  1'b1);
    issue(3'd7, 32'h0000_1234, 32'h0, 5'd10, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 5'($urandom), 1'b1);
      wait_idle();
    end

    // Flush at E0+10 with a competing start; neither may complete
    issue(3'd4, 32'd1000, 32'd3, 5'd13, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    bus.start_i = 1'b1;
    bus.op_i    = 3'd0;
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    issue(3'd0, 32'd6, 32'd9, 5'd14, 1'b1);
    wait_idle();
    repeat (40) @(negedge clk);

    // Start while busy in MUL and in DIV is ignored
    issue(3'd0, 32'd3, 32'd5, 5'd15, 1'b1);
    bus.start_i = 1'b1;
    bus.op_i    = 3'd4;
    bus.rs1_i   = 32'd77;
    bus.rs2_i   = 32'd2;
    bus.rd_i    = 5'd30;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_idle();
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd16, 1'b1);
    repeat (3) @(negedge clk);
    check("div_busy", 64'(bus.busy_o), 64'd1);
    bus.start_i = 1'b1;
    bus.op_i    = 3'd0;
    bus.rs1_i   = 32'd11;
    bus.rs2_i   = 32'd13;
    bus.rd_i    = 5'd31;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of a divide
    issue(3'd5, 32'd5000, 32'd9, 5'd17, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy_o), 64'd0);
    check("arst_valid", 64'(bus.valid_o), 64'd0);
    check("arst_result", 64'(bus.result_o), 64'd0);
    check("arst_rd", 64'(bus.rd_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", 64'(bus.busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
